// File: rtl/interrupt_pkg.sv
`default_nettype none
// ============================================================================
// Module : interrupt_pkg
// Brief  : Shared states, sources, vectors and status-bit helpers for the
//          interrupt sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package interrupt_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DUMMY    = 3'd1,
    S_PUSH_PCH = 3'd2,
    S_PUSH_PCL = 3'd3,
    S_PUSH_P   = 3'd4,
    S_VEC_LO   = 3'd5,
    S_VEC_HI   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SRC_RESET = 2'd0,
    SRC_NMI   = 2'd1,
    SRC_IRQ   = 2'd2,
    SRC_BRK   = 2'd3
  } src_t;

  localparam logic [15:0] C_VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] C_VEC_RESET  = 16'hFFFC;
  localparam logic [15:0] C_VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  C_STACK_PAGE = 8'h01;

  localparam int C_P_BIT_I = 2;
  localparam int C_P_BIT_B = 4;
  localparam int C_P_BIT_U = 5;

  function automatic logic [15:0] vector_of(input src_t src);
    case (src)
      SRC_RESET: vector_of = C_VEC_RESET;
      SRC_NMI:   vector_of = C_VEC_NMI;
      default:   vector_of = C_VEC_IRQ;
    endcase
  endfunction

  function automatic logic [7:0] pushed_p(input logic [7:0] p, input logic brk);
    pushed_p            = p;
    pushed_p[C_P_BIT_U] = 1'b1;
    pushed_p[C_P_BIT_B] = brk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module : interrupt_sequencer
// Brief  : Reset / NMI / IRQ / BRK entry sequence: dummy read, three stack
//          pushes, two vector reads. Optional macro INT_NMI_HIJACK_EN lets a
//          late NMI steal the vector of an IRQ/BRK sequence.
// Rev    : 1.0  initial release
// ============================================================================
module interrupt_sequencer
  import interrupt_pkg::*;
(
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic        int_req,
  input  logic        nmi_pending,
  input  logic        irq_pending,
  input  logic        brk_op,
  input  logic        rdy,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        rw,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_out,
  output logic        set_i,
  output logic        busy,
  output logic        int_clr,
  output logic        nmi_clr,
  output logic        done
);

  state_t      r_state;
  state_t      w_next;
  src_t        r_src;
  src_t        w_src;
  logic        r_reset_seq;
  logic [15:0] r_vec;
  logic [7:0]  r_pc_lo;
  logic [15:0] r_pc_out;
  logic        w_int_go;
  logic        w_go;
  logic        w_stall;
  logic        w_hijack;

  // An int_req with nothing pending is spurious and does not start a sequence.
  assign w_int_go = int_req & (nmi_pending | irq_pending);
  assign w_go     = r_reset_seq | w_int_go | brk_op;
  assign w_stall  = ~rdy & ((r_state == S_DUMMY) | (r_state == S_VEC_LO) |
                            (r_state == S_VEC_HI));

  always_comb begin
    w_src = SRC_BRK;
    if (r_reset_seq)   w_src = SRC_RESET;
    else if (w_int_go) w_src = nmi_pending ? SRC_NMI : SRC_IRQ;
  end

`ifdef INT_NMI_HIJACK_EN
  assign w_hijack = (r_state == S_PUSH_P) && nmi_pending &&
                    ((r_src == SRC_IRQ) || (r_src == SRC_BRK));
  assign nmi_clr  = (r_state == S_PUSH_P) && ((r_src == SRC_NMI) || w_hijack);
`else
  assign w_hijack = 1'b0;
  assign nmi_clr  = (r_state == S_IDLE) && w_go && (w_src == SRC_NMI);
`endif

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_reset_seq <= 1'b1;
      r_src       <= SRC_RESET;
      r_vec       <= 16'h0000;
      r_pc_lo     <= 8'h00;
      r_pc_out    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_go) begin
        r_src       <= w_src;
        r_vec       <= vector_of(w_src);
        r_reset_seq <= 1'b0;
      end
      if (w_hijack)
        r_vec <= C_VEC_NMI;
      if ((r_state == S_VEC_LO) && rdy)
        r_pc_lo <= din;
      if ((r_state == S_VEC_HI) && rdy)
        r_pc_out <= {din, r_pc_lo};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_go) w_next = S_DUMMY;
      S_DUMMY:    if (!w_stall) w_next = S_PUSH_PCH;
      S_PUSH_PCH: w_next = S_PUSH_PCL;
      S_PUSH_PCL: w_next = S_PUSH_P;
      S_PUSH_P:   w_next = S_VEC_LO;
      S_VEC_LO:   if (!w_stall) w_next = S_VEC_HI;
      S_VEC_HI:   if (!w_stall) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Reset sequences walk the push states as reads so the stack is untouched.
  always_comb begin
    addr    = 16'h0000;
    dout    = 8'h00;
    rw      = 1'b1;
    sp_dec  = 1'b0;
    pc_load = 1'b0;
    set_i   = 1'b0;
    done    = 1'b0;
    int_clr = 1'b0;
    pc_out  = r_pc_out;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_DUMMY: addr = pc_in;
      S_PUSH_PCH: begin
        addr   = {C_STACK_PAGE, sp_in};
        dout   = pc_in[15:8];
        rw     = (r_src == SRC_RESET);
        sp_dec = 1'b1;
      end
      S_PUSH_PCL: begin
        addr   = {C_STACK_PAGE, sp_in};
        dout   = pc_in[7:0];
        rw     = (r_src == SRC_RESET);
        sp_dec = 1'b1;
      end
      S_PUSH_P: begin
        addr   = {C_STACK_PAGE, sp_in};
        dout   = pushed_p(p_in, r_src == SRC_BRK);
        rw     = (r_src == SRC_RESET);
        sp_dec = 1'b1;
      end
      S_VEC_LO: addr = r_vec;
      S_VEC_HI: begin
        addr    = r_vec + 16'd1;
        pc_out  = {din, r_pc_lo};
        pc_load = rdy;
        set_i   = rdy;
        done    = rdy;
        int_clr = rdy & (r_src != SRC_BRK);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
